// File: rtl/sram_wb_bridge_pkg.sv
// Shared types and helpers for the Wishbone-to-SRAM bridge.
// Holds the FSM state encoding and the byte-lane merge primitive.
package sram_wb_bridge_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RD_ISSUE  = 4'd1,
    RD_WAIT   = 4'd2,
    RD_CAP    = 4'd3,
    WR_ISSUE  = 4'd4,
    RMW_ISSUE = 4'd5,
    RMW_WAIT  = 4'd6,
    RMW_CAP   = 4'd7,
    RMW_WR    = 4'd8,
    RESP      = 4'd9
  } state_e;

  // Number of byte lanes in a data word of the given width.
  function automatic int unsigned sel_width(input int unsigned dsize);
    return dsize / BYTE_W;
  endfunction

  // One byte lane of a read-modify-write: take the new byte when its lane is selected.
  function automatic logic [BYTE_W-1:0] merge_byte(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              sel
  );
    return sel ? new_b : old_b;
  endfunction

endpackage

// File: rtl/sram_byte_merge.sv
// Combinational byte-lane merge of a write word into the word read back from SRAM.
module sram_byte_merge
  import sram_wb_bridge_pkg::*;
#(
  parameter int unsigned DSIZE = 32
) (
  input  logic [DSIZE-1:0]        old_i,
  input  logic [DSIZE-1:0]        new_i,
  input  logic [DSIZE/BYTE_W-1:0] sel_i,
  output logic [DSIZE-1:0]        merged_c
);

  localparam int unsigned SEL_W = sel_width(DSIZE);

  for (genvar k = 0; k < SEL_W; k++) begin : g_lane
    assign merged_c[k*BYTE_W +: BYTE_W] = merge_byte(old_i[k*BYTE_W +: BYTE_W],
                                                     new_i[k*BYTE_W +: BYTE_W],
                                                     sel_i[k]);
  end

endmodule

// File: rtl/sram_wb_bridge.sv
// Wishbone classic slave driving port 0 of a registered-input SRAM macro.
// Hides the two-cycle read latency and performs read-modify-write for partial writes.
module sram_wb_bridge
  import sram_wb_bridge_pkg::*;
#(
  parameter int unsigned ASIZE    = 8,
  parameter int unsigned DSIZE    = 32,
  parameter int unsigned BASE_LSB = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [31:0]             wb_adr_i,
  input  logic [DSIZE/BYTE_W-1:0] wb_sel_i,
  input  logic [DSIZE-1:0]        wb_dat_i,
  output logic [DSIZE-1:0]        wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    sram_cs_n,
  output logic                    sram_we_n,
  output logic [ASIZE-1:0]        sram_addr,
  output logic [DSIZE-1:0]        sram_wdata,
  input  logic [DSIZE-1:0]        sram_rdata
);

  localparam int unsigned SEL_W   = sel_width(DSIZE);
  localparam int unsigned TOP_LSB = BASE_LSB + ASIZE;
  localparam logic [SEL_W-1:0] SEL_ALL = '1;

  state_e             state_q, state_d;
  logic               sram_cs_n_q, sram_cs_n_d;
  logic               sram_we_n_q, sram_we_n_d;
  logic [ASIZE-1:0]   sram_addr_q, sram_addr_d;
  logic [DSIZE-1:0]   sram_wdata_q, sram_wdata_d;
  logic               wb_ack_q, wb_ack_d;
  logic               wb_err_q, wb_err_d;
  logic [DSIZE-1:0]   wb_dat_q, wb_dat_d;
  logic [DSIZE-1:0]   dat_q, dat_d;
  logic [SEL_W-1:0]   sel_q, sel_d;

  logic               req_valid;
  logic               out_of_range;
  logic               sel_full;
  logic               sel_none;
  logic [ASIZE-1:0]   word_addr;
  logic [DSIZE-1:0]   merged_c;

  // Request decode; the ack/err terms keep a held strobe from re-triggering in RESP.
  assign req_valid    = wb_cyc_i & wb_stb_i & ~wb_ack_q & ~wb_err_q;
  assign out_of_range = (wb_adr_i >> TOP_LSB) != 32'd0;
  assign word_addr    = wb_adr_i[BASE_LSB +: ASIZE];
  assign sel_full     = (wb_sel_i == SEL_ALL);
  assign sel_none     = (wb_sel_i == '0);

  sram_byte_merge #(
    .DSIZE (DSIZE)
  ) u_merge (
    .old_i    (sram_rdata),
    .new_i    (dat_q),
    .sel_i    (sel_q),
    .merged_c (merged_c)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sram_cs_n_q  <= 1'b1;
      sram_we_n_q  <= 1'b1;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      wb_ack_q     <= 1'b0;
      wb_err_q     <= 1'b0;
      wb_dat_q     <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
    end else begin
      state_q      <= state_d;
      sram_cs_n_q  <= sram_cs_n_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      wb_ack_q     <= wb_ack_d;
      wb_err_q     <= wb_err_d;
      wb_dat_q     <= wb_dat_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
    end
  end

  // Next-state logic; a dropped wb_cyc_i abandons the transaction without a response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (out_of_range)  state_d = RESP;
          else if (!wb_we_i) state_d = RD_ISSUE;
          else if (sel_none) state_d = RESP;
          else if (sel_full) state_d = WR_ISSUE;
          else               state_d = RMW_ISSUE;
        end
      end
      RD_ISSUE:  state_d = wb_cyc_i ? RD_WAIT  : IDLE;
      RD_WAIT:   state_d = wb_cyc_i ? RD_CAP   : IDLE;
      RD_CAP:    state_d = wb_cyc_i ? RESP     : IDLE;
      WR_ISSUE:  state_d = wb_cyc_i ? RESP     : IDLE;
      RMW_ISSUE: state_d = wb_cyc_i ? RMW_WAIT : IDLE;
      RMW_WAIT:  state_d = wb_cyc_i ? RMW_CAP  : IDLE;
      RMW_CAP:   state_d = wb_cyc_i ? RMW_WR   : IDLE;
      RMW_WR:    state_d = wb_cyc_i ? RESP     : IDLE;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output logic: each registered output is computed one cycle ahead of its use.
  always_comb begin
    sram_cs_n_d  = 1'b1;
    sram_we_n_d  = 1'b1;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    wb_ack_d     = 1'b0;
    wb_err_d     = 1'b0;
    wb_dat_d     = wb_dat_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          dat_d = wb_dat_i;
          sel_d = wb_sel_i;
          if (out_of_range) begin
            wb_err_d = 1'b1;
          end else if (wb_we_i && sel_none) begin
            wb_ack_d = 1'b1;
          end else begin
            sram_cs_n_d = 1'b0;
            sram_addr_d = word_addr;
            if (wb_we_i && sel_full) begin
              sram_we_n_d  = 1'b0;
              sram_wdata_d = wb_dat_i;
            end
          end
        end
      end
      RD_CAP: begin
        if (wb_cyc_i) begin
          wb_dat_d = sram_rdata;
          wb_ack_d = 1'b1;
        end
      end
      WR_ISSUE: begin
        if (wb_cyc_i) wb_ack_d = 1'b1;
      end
      RMW_CAP: begin
        if (wb_cyc_i) begin
          sram_cs_n_d  = 1'b0;
          sram_we_n_d  = 1'b0;
          sram_wdata_d = merged_c;
        end
      end
      RMW_WR: begin
        if (wb_cyc_i) wb_ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_cs_n  = sram_cs_n_q;
  assign sram_we_n  = sram_we_n_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign wb_ack_o   = wb_ack_q;
  assign wb_err_o   = wb_err_q;
  assign wb_dat_o   = wb_dat_q;

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Bench for sram_wb_bridge: directed cases plus randomized traffic against a word-level memory model.
module tb_sram_wb_bridge;

  localparam int unsigned ASIZE    = 8;
  localparam int unsigned DSIZE    = 32;
  localparam int unsigned BASE_LSB = 2;
  localparam int          MAXC     = 8;
  localparam int          NPRE     = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic        sram_cs_n, sram_we_n;
  logic [7:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  always #5 clk = ~clk;

  sram_wb_bridge #(
    .ASIZE    (ASIZE),
    .DSIZE    (DSIZE),
    .BASE_LSB (BASE_LSB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_sel_i   (wb_sel_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .sram_cs_n  (sram_cs_n),
    .sram_we_n  (sram_we_n),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Registered-input SRAM: read data valid two cycles after the strobe, write lands one cycle after.
  logic [31:0] sram_mem [256];
  logic        s1_rd, s1_wr;
  logic [7:0]  s1_addr;
  logic [31:0] s1_wdata;
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    s1_rd    <= !sram_cs_n && sram_we_n;
    s1_wr    <= !sram_cs_n && !sram_we_n;
    s1_addr  <= sram_addr;
    s1_wdata <= sram_wdata;
    if (s1_wr)  sram_mem[s1_addr] <= s1_wdata;
    if (s1_rd)  sram_rdata <= sram_mem[s1_addr];
    if (pre_en) sram_mem[pre_addr] <= pre_data;
  end

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] last_rd;

  int          m_ack_cnt, m_ack_cyc, m_err_cnt, m_err_cyc, m_n_strb, m_n_wr;
  int          m_s_cyc   [4];
  logic        m_s_we_n  [4];
  logic [7:0]  m_s_addr  [4];
  logic [31:0] m_s_wdata [4];
  logic [31:0] m_rdat;
  logic        snap_cs_n, snap_we_n, snap_ack, snap_err;
  logic [7:0]  snap_addr;
  logic [31:0] snap_wdata, snap_dat_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request from cycle 0 and record every strobe/response over a fixed window.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input int drop_cyc, input int rst_cyc);
    m_ack_cnt = 0; m_ack_cyc = -1; m_err_cnt = 0; m_err_cyc = -1;
    m_n_strb = 0;  m_n_wr = 0;     m_rdat = '0;
    for (int i = 0; i < 4; i++) begin
      m_s_cyc[i] = -1; m_s_we_n[i] = 1'bx; m_s_addr[i] = 'x; m_s_wdata[i] = 'x;
    end
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
    for (int k = 1; k <= MAXC; k++) begin
      @(posedge clk); #1;
      if (!sram_cs_n) begin
        if (m_n_strb < 4) begin
          m_s_cyc[m_n_strb]   = k;
          m_s_we_n[m_n_strb]  = sram_we_n;
          m_s_addr[m_n_strb]  = sram_addr;
          m_s_wdata[m_n_strb] = sram_wdata;
        end
        m_n_strb++;
        if (!sram_we_n) m_n_wr++;
      end
      if (wb_ack_o) begin
        if (m_ack_cnt == 0) begin m_ack_cyc = k; m_rdat = wb_dat_o; end
        m_ack_cnt++;
      end
      if (wb_err_o) begin
        if (m_err_cnt == 0) m_err_cyc = k;
        m_err_cnt++;
      end
      if (rst_cyc > 0 && k == rst_cyc + 1) begin
        snap_cs_n = sram_cs_n; snap_we_n = sram_we_n; snap_addr = sram_addr;
        snap_wdata = sram_wdata; snap_ack = wb_ack_o; snap_err = wb_err_o; snap_dat_o = wb_dat_o;
        rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      if (k == 1) begin
        wb_adr_i = $urandom; wb_dat_i = $urandom; wb_sel_i = 4'($urandom);
      end
      if (wb_ack_o || wb_err_o || k == drop_cyc) begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      if (k == rst_cyc) rst = 1'b1;
    end
  endtask

  // Expected behaviour derived from the bus rules, then checked and applied to the model.
  task automatic txn_check(input string tag, input logic we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat);
    logic        oor;
    int          w;
    logic [31:0] old_w, mask, exp_w;
    oor   = (adr >= 32'h400);
    w     = int'(adr[9:2]);
    old_w = ref_mem[w];
    mask  = '0;
    for (int k = 0; k < 4; k++) if (sel[k]) mask = mask | (32'hFF << (8 * k));
    exp_w = (dat & mask) | (old_w & ~mask);
    run_txn(we, adr, sel, dat, 0, 0);
    if (oor) begin
      chk({tag, "_err_cyc"}, 32'(m_err_cyc), 32'd1);
      chk({tag, "_err_cnt"}, 32'(m_err_cnt), 32'd1);
      chk({tag, "_ack_cnt"}, 32'(m_ack_cnt), 32'd0);
      chk({tag, "_strobes"}, 32'(m_n_strb), 32'd0);
    end else begin
      chk({tag, "_err_cnt"}, 32'(m_err_cnt), 32'd0);
      chk({tag, "_ack_cnt"}, 32'(m_ack_cnt), 32'd1);
      if (!we) begin
        chk({tag, "_ack_cyc"}, 32'(m_ack_cyc), 32'd4);
        chk({tag, "_strobes"}, 32'(m_n_strb), 32'd1);
        chk({tag, "_s0_cyc"},  32'(m_s_cyc[0]), 32'd1);
        chk({tag, "_s0_we_n"}, 32'(m_s_we_n[0]), 32'd1);
        chk({tag, "_s0_addr"}, 32'(m_s_addr[0]), 32'(w));
        chk({tag, "_rdata"},   m_rdat, old_w);
        last_rd = old_w;
      end else if (sel == 4'h0) begin
        chk({tag, "_ack_cyc"}, 32'(m_ack_cyc), 32'd1);
        chk({tag, "_strobes"}, 32'(m_n_strb), 32'd0);
      end else if (sel == 4'hF) begin
        chk({tag, "_ack_cyc"}, 32'(m_ack_cyc), 32'd2);
        chk({tag, "_strobes"}, 32'(m_n_strb), 32'd1);
        chk({tag, "_s0_cyc"},  32'(m_s_cyc[0]), 32'd1);
        chk({tag, "_s0_we_n"}, 32'(m_s_we_n[0]), 32'd0);
        chk({tag, "_s0_addr"}, 32'(m_s_addr[0]), 32'(w));
        chk({tag, "_s0_wdat"}, m_s_wdata[0], dat);
        ref_mem[w] = dat;
      end else begin
        chk({tag, "_ack_cyc"}, 32'(m_ack_cyc), 32'd5);
        chk({tag, "_strobes"}, 32'(m_n_strb), 32'd2);
        chk({tag, "_s0_cyc"},  32'(m_s_cyc[0]), 32'd1);
        chk({tag, "_s0_we_n"}, 32'(m_s_we_n[0]), 32'd1);
        chk({tag, "_s0_addr"}, 32'(m_s_addr[0]), 32'(w));
        chk({tag, "_s1_cyc"},  32'(m_s_cyc[1]), 32'd4);
        chk({tag, "_s1_we_n"}, 32'(m_s_we_n[1]), 32'd0);
        chk({tag, "_s1_addr"}, 32'(m_s_addr[1]), 32'(w));
        chk({tag, "_s1_wdat"}, m_s_wdata[1], exp_w);
        ref_mem[w] = exp_w;
      end
    end
    chk({tag, "_dat_o"}, wb_dat_o, last_rd);
  endtask

  initial begin
    logic        r_we;
    logic [31:0] r_adr;
    rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    last_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n",  32'(sram_cs_n), 32'd1);
    chk("rst_we_n",  32'(sram_we_n), 32'd1);
    chk("rst_addr",  32'(sram_addr), 32'd0);
    chk("rst_wdata", sram_wdata,     32'd0);
    chk("rst_ack",   32'(wb_ack_o),  32'd0);
    chk("rst_err",   32'(wb_err_o),  32'd0);
    chk("rst_dat_o", wb_dat_o,       32'd0);

    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int i = 0; i < NPRE; i++) begin
      pre_en = 1'b1; pre_addr = 8'(i); pre_data = $urandom; ref_mem[i] = pre_data;
      @(posedge clk); #1;
    end
    pre_en = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // 1: full write then readback
    txn_check("t1_wr", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    txn_check("t1_rd", 1'b0, 32'h10, 4'hF, 32'h0);
    chk("t1_value", m_rdat, 32'hDEADBEEF);

    // 2: partial write merges bytes 0 and 2
    txn_check("t2_rmw", 1'b1, 32'h10, 4'h5, 32'h11223344);
    chk("t2_merge", m_s_wdata[1], 32'hDE22BE44);
    txn_check("t2_rd", 1'b0, 32'h10, 4'h0, 32'h0);
    chk("t2_value", m_rdat, 32'hDE22BE44);

    // 3: out of range
    txn_check("t3_oor", 1'b0, 32'h400, 4'hF, 32'h0);

    // 4: sel=0 write leaves memory untouched
    txn_check("t4_sel0", 1'b1, 32'h20, 4'h0, 32'hCAFEF00D);
    txn_check("t4_rd", 1'b0, 32'h20, 4'hF, 32'h0);

    // 5: read aborted in cycle 2, then a normal read
    run_txn(1'b0, 32'h10, 4'hF, 32'h0, 2, 0);
    chk("t5_ack_cnt", 32'(m_ack_cnt), 32'd0);
    chk("t5_err_cnt", 32'(m_err_cnt), 32'd0);
    chk("t5_strobes", 32'(m_n_strb), 32'd1);
    txn_check("t5_rd", 1'b0, 32'h10, 4'hF, 32'h0);

    // 6: reset in cycle 2 of a read-modify-write
    run_txn(1'b1, 32'h18, 4'h3, 32'hA5A5A5A5, 0, 2);
    chk("t6_cs_n",   32'(snap_cs_n), 32'd1);
    chk("t6_we_n",   32'(snap_we_n), 32'd1);
    chk("t6_addr",   32'(snap_addr), 32'd0);
    chk("t6_wdata",  snap_wdata,     32'd0);
    chk("t6_ack",    32'(snap_ack),  32'd0);
    chk("t6_err",    32'(snap_err),  32'd0);
    chk("t6_dat_o",  snap_dat_o,     32'd0);
    chk("t6_writes", 32'(m_n_wr),    32'd0);
    chk("t6_ack_cnt", 32'(m_ack_cnt), 32'd0);
    last_rd = '0;
    txn_check("t6_rd", 1'b0, 32'h18, 4'hF, 32'h0);

    // Randomized traffic over the preloaded words with occasional out-of-range hits
    for (int n = 0; n < 60; n++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) r_adr = $urandom | 32'h400;
      else r_adr = (32'($urandom_range(0, NPRE - 1)) << 2) | 32'($urandom_range(0, 3));
      txn_check("rnd", r_we, r_adr, 4'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
